// File: rtl/idsadc_dig_core.sv
// Incremental delta-sigma ADC back-end: conversion sequencer, ORDER-stage integrator cascade per channel, Wishbone regs.
// Define IDSADC_SYNC_EN to pass mod_bit_i through a 2-flop synchronizer (adds 2 cycles before CONV).
module idsadc_dig_core #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned NCH      = 2,
  parameter int unsigned ORDER    = 2,
  parameter int unsigned OSR_W    = 10
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_cyc_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  input  logic [NCH-1:0] mod_bit_i,
  output logic           mod_rst_o,
  output logic           busy_o,
  output logic           irq_o
);
  localparam int unsigned ACC_W = ORDER * OSR_W;
  localparam int unsigned CNT_W = (OSR_W > 8) ? OSR_W : 8;

  if (ACC_W > 32) begin : g_acc_w_chk
    $error("idsadc_dig_core: ORDER*OSR_W must not exceed 32");
  end
  if (NCH < 1 || NCH > 8 || ORDER < 1 || ORDER > 3) begin : g_param_chk
    $error("idsadc_dig_core: NCH must be 1..8 and ORDER 1..3");
  end

  typedef enum logic [2:0] {S_IDLE, S_RST, S_SYNC, S_CONV, S_LATCH} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt, conv_len;
  logic             cont, irq_en, done, overrun, start_p, abort_p;
  logic [NCH-1:0]   ch_mask, mask_s, samp;
  logic [OSR_W-1:0] osr, osr_s;
  logic [7:0]       settle;
  logic [ACC_W-1:0] data [NCH];
  logic [ACC_W-1:0] integ [NCH][ORDER];
  logic [ACC_W-1:0] nxt [NCH][ORDER];
  logic [ACC_W-1:0] acc;

  logic [31:0] off, rdata, wmask, merged;
  logic [29:0] widx;
  logic        hit, wb_req, wr;

`ifdef IDSADC_SYNC_EN
  logic [NCH-1:0] sync1, sync2;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= mod_bit_i;
      sync2 <= sync1;
    end
  end
  assign samp = sync2;
`else
  assign samp = mod_bit_i;
`endif

  assign wb_req   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign off      = wbs_adr_i - BASE_ADR;
  assign widx     = off[31:2];
  assign hit      = (off[1:0] == 2'b00) && (off < 32'(16 + 4 * NCH));
  assign wr       = wb_req & wbs_we_i & hit;
  assign wmask    = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  // Byte-lane merge against the current read view of the addressed register.
  assign merged   = (rdata & ~wmask) | (wbs_dat_i & wmask);
  assign conv_len = (osr_s == '0) ? '0 : CNT_W'(osr_s - 1'b1);
  assign irq_o    = done & irq_en;

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (widx)
        30'd0: begin
          rdata[1]       = cont;
          rdata[2]       = irq_en;
          rdata[8 +: NCH] = ch_mask;
        end
        30'd1: rdata[OSR_W-1:0] = osr;
        30'd2: rdata[7:0]       = settle;
        30'd3: rdata[2:0]       = {overrun, done, busy_o};
        default: begin
          for (int unsigned c = 0; c < NCH; c++)
            if (widx == 30'(4 + c)) rdata = 32'(data[c]);
        end
      endcase
    end
  end

  always_comb begin
    acc = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      acc = ACC_W'(samp[c]);
      for (int unsigned k = 0; k < ORDER; k++) begin
        acc       = integ[c][k] + acc;
        nxt[c][k] = acc;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int unsigned c = 0; c < NCH; c++)
        for (int unsigned k = 0; k < ORDER; k++)
          integ[c][k] <= '0;
    end else if (abort_p || state == S_IDLE || state == S_RST) begin
      for (int unsigned c = 0; c < NCH; c++)
        for (int unsigned k = 0; k < ORDER; k++)
          integ[c][k] <= '0;
    end else if (state == S_CONV) begin
      for (int unsigned c = 0; c < NCH; c++)
        if (mask_s[c])
          for (int unsigned k = 0; k < ORDER; k++)
            integ[c][k] <= nxt[c][k];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      cont      <= 1'b0;
      irq_en    <= 1'b0;
      ch_mask   <= '0;
      osr       <= '0;
      settle    <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      start_p   <= 1'b0;
      abort_p   <= 1'b0;
      state     <= S_IDLE;
      cnt       <= '0;
      osr_s     <= '0;
      mask_s    <= '0;
      mod_rst_o <= 1'b1;
      busy_o    <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) data[c] <= '0;
    end else begin
      wbs_ack_o <= wb_req;
      wbs_dat_o <= wb_req ? rdata : '0;
      start_p   <= 1'b0;
      abort_p   <= 1'b0;
      if (wr) begin
        case (widx)
          30'd0: begin
            cont    <= merged[1];
            irq_en  <= merged[2];
            ch_mask <= merged[8 +: NCH];
            abort_p <= merged[3];
            start_p <= merged[0] & ~merged[3] & (state == S_IDLE);
          end
          30'd1: osr    <= merged[OSR_W-1:0];
          30'd2: settle <= merged[7:0];
          30'd3: begin
            if (wbs_dat_i[1] & wbs_sel_i[0]) done    <= 1'b0;
            if (wbs_dat_i[2] & wbs_sel_i[0]) overrun <= 1'b0;
          end
          default: ;
        endcase
      end
      // Sequencer follows the register writes so a LATCH done-set overrides a same-cycle clear.
      if (abort_p) begin
        state     <= S_IDLE;
        mod_rst_o <= 1'b1;
        busy_o    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_p) begin
              state  <= S_RST;
              busy_o <= 1'b1;
              osr_s  <= osr;
              mask_s <= ch_mask;
              cnt    <= CNT_W'(settle);
            end
          end
          S_RST: begin
            if (cnt == '0) begin
              mod_rst_o <= 1'b0;
`ifdef IDSADC_SYNC_EN
              state     <= S_SYNC;
              cnt       <= CNT_W'(1);
`else
              state     <= S_CONV;
              cnt       <= conv_len;
`endif
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_SYNC: begin
            if (cnt == '0) begin
              state <= S_CONV;
              cnt   <= conv_len;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_CONV: begin
            if (cnt == '0) begin
              state     <= S_LATCH;
              mod_rst_o <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_LATCH: begin
            for (int unsigned c = 0; c < NCH; c++)
              if (mask_s[c]) data[c] <= integ[c][ORDER-1];
            done <= 1'b1;
            if (done) overrun <= 1'b1;
            if (cont) begin
              state  <= S_RST;
              osr_s  <= osr;
              mask_s <= ch_mask;
              cnt    <= CNT_W'(settle);
            end else begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end
          end
          default: begin
            state     <= S_IDLE;
            mod_rst_o <= 1'b1;
            busy_o    <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_idsadc_dig_core.sv
// Directed bench for idsadc_dig_core (default build): conversion results, latency, CONT/overrun, ABORT, mask, reset.
module tb_idsadc_dig_core;
  localparam logic [31:0] B    = 32'h3000_0000;
  localparam logic [31:0] CTRL = B;
  localparam logic [31:0] OSRA = B + 32'h04;
  localparam logic [31:0] SETA = B + 32'h08;
  localparam logic [31:0] STAT = B + 32'h0C;
  localparam logic [31:0] D0   = B + 32'h10;
  localparam logic [31:0] D1   = B + 32'h14;

  logic        clk = 1'b0, rst;
  logic        stb, cyc, we, ack, mod_rst, busy, irq;
  logic [3:0]  sel;
  logic [31:0] adr, dat, dout;
  logic [1:0]  mod_bit;

  int total = 0, bad = 0, cyc_cnt = 0, t_ack = 0;
  logic [31:0] exp_q[$];
  logic        alt = 1'b0;
  logic [1:0]  base_bits = 2'b00;

  idsadc_dig_core #(.BASE_ADR(B), .NCH(2), .ORDER(2), .OSR_W(10)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dout),
    .mod_bit_i(mod_bit), .mod_rst_o(mod_rst), .busy_o(busy), .irq_o(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd);
    int n;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (ack !== 1'b1 && n < 16);
    t_ack = cyc_cnt;
    rd = dout;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    chk("wb_ack", {31'b0, ack}, 32'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(1'b1, a, d, 4'hF, r);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] expv);
    logic [31:0] r;
    wb_xfer(1'b0, a, 32'h0, 4'hF, r);
    chk(tag, r, expv);
  endtask

  // Drives the modulator pattern while mod_rst_o is low and returns the edge at which irq_o rises.
  task automatic wait_conv(output int irq_edge, output int low_cnt, output logic busy_t1);
    int phase;
    phase = 0; irq_edge = -1; low_cnt = 0; busy_t1 = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (n == 0) busy_t1 = busy;
      if (!mod_rst) begin
        low_cnt++;
        mod_bit = alt ? {base_bits[1], (phase % 2 == 0)} : base_bits;
        phase++;
      end
      if (irq) begin
        irq_edge = cyc_cnt;
        break;
      end
    end
  endtask

  task automatic wait_conv_start();
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (!mod_rst) break;
    end
    chk("conv_entered", {31'b0, mod_rst}, 32'd0);
  endtask

  task automatic run_one(input string tag, input logic [31:0] exp_lat, input logic [31:0] exp_low);
    int t, ie, lo;
    logic b1;
    mod_bit = base_bits;
    wr(CTRL, 32'h105);
    t = t_ack;
    wait_conv(ie, lo, b1);
    chk({tag, "_busy_t1"}, {31'b0, b1}, 32'd1);
    chk({tag, "_latency"}, 32'(ie - t), exp_lat);
    chk({tag, "_rst_low"}, 32'(lo), exp_low);
    rd_chk({tag, "_data0"}, D0, exp_q.pop_front());
    rd_chk({tag, "_status"}, STAT, 32'h2);
    wr(STAT, 32'h2);
    chk({tag, "_irq_clr"}, {31'b0, irq}, 32'd0);
  endtask

  initial begin
    int t, ie, lo, cnt_lo;
    logic b1;
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    adr = '0; dat = '0; mod_bit = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_dat", dout, 32'd0);
    chk("rst_modrst", {31'b0, mod_rst}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    @(negedge clk) rst = 1'b0;
    rd_chk("rst_ctrl", CTRL, 32'h0);
    rd_chk("rst_osr", OSRA, 32'h0);
    rd_chk("rst_settle", SETA, 32'h0);
    rd_chk("rst_status", STAT, 32'h0);
    rd_chk("rst_data0", D0, 32'h0);
    rd_chk("rst_data1", D1, 32'h0);

    wr(OSRA, 32'd8);
    wr(SETA, 32'd2);
    wr(CTRL, 32'h104);

    base_bits = 2'b01; alt = 1'b0; exp_q.push_back(32'd36);
    run_one("ones", 32'd13, 32'd8);
    base_bits = 2'b00; alt = 1'b1; exp_q.push_back(32'd20);
    run_one("alt", 32'd13, 32'd8);
    base_bits = 2'b00; alt = 1'b0; exp_q.push_back(32'd0);
    run_one("zeros", 32'd13, 32'd8);

    // OSR=0 still takes one sample.
    wr(OSRA, 32'd0);
    base_bits = 2'b01; exp_q.push_back(32'd1);
    run_one("osr0", 32'd6, 32'd1);

    wb_xfer(1'b1, OSRA, 32'h3FF, 4'b0001, dat);
    rd_chk("osr_bytelane", OSRA, 32'h0FF);
    wr(OSRA, 32'd8);

    // Continuous mode, done never cleared -> overrun.
    base_bits = 2'b01; mod_bit = base_bits;
    wr(CTRL, 32'h106);
    exp_q.push_back(32'd36);
    wr(CTRL, 32'h107);
    t = t_ack;
    wait_conv(ie, lo, b1);
    chk("cont_latency", 32'(ie - t), 32'd13);
    cnt_lo = 0;
    for (int n = 0; n < 14; n++) begin
      @(posedge clk); #1;
      if (!irq) cnt_lo++;
    end
    chk("cont_irq_hold", 32'(cnt_lo), 32'd0);
    rd_chk("cont_status", STAT, 32'h7);
    wr(CTRL, 32'h104);
    repeat (20) @(posedge clk);
    #1;
    chk("cont_stop_busy", {31'b0, busy}, 32'd0);
    rd_chk("cont_data0", D0, exp_q.pop_front());
    wr(STAT, 32'h6);
    rd_chk("cont_w1c", STAT, 32'h0);
    chk("cont_irq_clr", {31'b0, irq}, 32'd0);

    // ABORT a few cycles into CONV with zeros on the input.
    base_bits = 2'b00; mod_bit = base_bits;
    exp_q.push_back(32'd36);
    wr(CTRL, 32'h105);
    wait_conv_start();
    repeat (2) @(posedge clk);
    wr(CTRL, 32'h10C);
    @(posedge clk); #1;
    chk("abort_modrst", {31'b0, mod_rst}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_irq", {31'b0, irq}, 32'd0);
    rd_chk("abort_status", STAT, 32'h0);
    rd_chk("abort_data0", D0, exp_q.pop_front());

    // Mask = ch1 only; second START while busy is ignored.
    base_bits = 2'b10; mod_bit = base_bits;
    exp_q.push_back(32'd36);
    exp_q.push_back(32'd36);
    wr(CTRL, 32'h204);
    wr(CTRL, 32'h205);
    t = t_ack;
    wr(CTRL, 32'h205);
    wait_conv(ie, lo, b1);
    chk("mask_latency", 32'(ie - t), 32'd13);
    repeat (3) @(posedge clk);
    #1;
    chk("mask_no_restart", {31'b0, busy}, 32'd0);
    rd_chk("mask_data1", D1, exp_q.pop_front());
    rd_chk("mask_data0", D0, exp_q.pop_front());

    rd_chk("unmapped_rd", B + 32'h40, 32'h0);
    wr(B + 32'h40, 32'hFFFF_FFFF);
    rd_chk("unmapped_wr", CTRL, 32'h204);

    // Reset mid-CONV with done/irq still set.
    chk("pre_rst_irq", {31'b0, irq}, 32'd1);
    base_bits = 2'b11; mod_bit = base_bits;
    wr(CTRL, 32'h205);
    wait_conv_start();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_modrst", {31'b0, mod_rst}, 32'd1);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_irq", {31'b0, irq}, 32'd0);
    chk("arst_ack", {31'b0, ack}, 32'd0);
    @(negedge clk) rst = 1'b0;
    rd_chk("arst_ctrl", CTRL, 32'h0);
    rd_chk("arst_osr", OSRA, 32'h0);
    rd_chk("arst_status", STAT, 32'h0);
    rd_chk("arst_data0", D0, 32'h0);
    rd_chk("arst_data1", D1, 32'h0);

    wr(OSRA, 32'd8);
    wr(SETA, 32'd2);
    wr(CTRL, 32'h104);
    base_bits = 2'b01; alt = 1'b0; exp_q.push_back(32'd36);
    run_one("post_rst", 32'd13, 32'd8);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/idsadc_dig_core.md
# idsadc_dig_core

Parametrised digital back-end for the incremental delta-sigma ADC in the Caravel user area. It sequences conversions for NCH modulators and resets the analog integrators between them. Each channel's 1-bit stream is decimated by an ORDER-stage cascaded-integrator filter. Results, control and status are exposed to the management core over Wishbone, with a completion interrupt. It replaces the empty user-project slot and drives the analog macro's reset and sample interface.

## Interface
- BASE_ADR, 32'h3000_0000: Wishbone base address; block decodes BASE_ADR+0x00..0x10+4*(NCH-1).
- NCH, 2: modulator channels, 1..8.
- ORDER, 2: integrator cascade order, 1..3.
- OSR_W, 10: width of the oversampling-ratio register.
- Derived ACC_W = ORDER*OSR_W. Must be ≤ 32; elaboration error otherwise.

- wb_clk_i  in  1  single clock for the block and the modulators.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe, cycle and write.
- wbs_sel_i  in  4  byte-lane enables for writes.
- wbs_adr_i, wbs_dat_i  in  32 each  address and write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data, 0 when not acking.
- mod_bit_i  in  NCH  modulator output bits, one per channel.
- mod_rst_o  out  1  modulator integrator reset, high = hold.
- busy_o  out  1  conversion in progress.
- irq_o  out  1  level interrupt, = done & irq_en.

## Operation
Register map (byte offsets):
- 0x00 CTRL
  - [0] START, write-1 pulse.
  - [1] CONT, continuous conversions.
  - [2] IRQ_EN.
  - [3] ABORT, write-1 pulse.
  - [8+NCH-1:8] channel enable mask.
- 0x04 OSR [OSR_W-1:0] = N. Conversion length is max(N,1) samples.
- 0x08 SETTLE [7:0] = S. mod_rst_o stays high S+1 cycles before sampling.
- 0x0C STATUS
  - [0] busy, read-only.
  - [1] done, write-1-to-clear.
  - [2] overrun, write-1-to-clear.
- 0x10+4*ch DATA_ch: [ACC_W-1:0] last result, upper bits 0, read-only.
- Writes honour byte lanes. Unmapped addresses ack, read 0 and ignore writes.

State machine:
- IDLE: mod_rst_o=1. START → RST.
- RST: mod_rst_o=1 and integrators cleared. After S+1 cycles → CONV.
- CONV: mod_rst_o=0. Each cycle, enabled channel c computes i1+=mod_bit_i[c] and ik+=i(k-1) for k=2..ORDER. After max(N,1) cycles → LATCH.
  - Accumulators are ACC_W bits and wrap modulo 2^ACC_W. With ACC_W = ORDER*OSR_W they cannot overflow for N < 2^OSR_W.
- LATCH: one cycle. DATA_c ← i_ORDER for enabled channels; disabled channels keep their old value. Set done; if done was already 1, also set overrun. Then → RST if CONT=1, else → IDLE.

Boundary rules:
- START while busy is ignored.
- ABORT in any state → IDLE next cycle. DATA and done are unchanged, integrators cleared.
- START and ABORT in the same write: ABORT wins.
- Clearing CONT mid-conversion finishes the current conversion, then → IDLE.
- OSR, SETTLE and the channel mask are sampled on entry to RST; changes mid-conversion take effect on the next conversion.
- A STATUS done-clear in the same cycle as LATCH: the set wins.
- Reset mid-conversion: immediate IDLE, all registers cleared.

Reset values:
- Outputs: wbs_ack_o=0, wbs_dat_o=0, mod_rst_o=1, busy_o=0, irq_o=0.
- Registers: CTRL=0, OSR=0, SETTLE=0, STATUS=0, DATA=0.

## Timing
- Wishbone: ack asserts the cycle after stb&cyc and stays high 1 cycle. At most one ack per 2 cycles (no back-to-back). Read data is valid with ack.
- Write side effects occur on the ack edge.
- A START write acked at edge T gives RST at T+1; mod_rst_o falls at T+1+S+1.
- CONV spans max(N,1) cycles, so DATA, done and irq_o update at T+S+N+3.
- busy_o is high from T+1 through the LATCH cycle.
- Continuous mode adds S+1 cycles between conversions. No idle cycle after LATCH.

## Configuration
- IDSADC_SYNC_EN defined: mod_bit_i passes through a 2-flop synchronizer. CONV start is delayed 2 cycles so the first captured sample is the first one taken after mod_rst_o falls. Completion moves to T+S+N+5.
- IDSADC_SYNC_EN undefined: mod_bit_i is sampled directly in CONV, for modulators clocked by wb_clk_i. Timing is as above.

## Test plan
- Defaults, OSR=8, SETTLE=2, mask=0x1, mod_bit_i[0]=1 constant, START: DATA_0=36 (0x24), done=1 at T+13, mod_rst_o low exactly 8 cycles.
- Same setup, alternating 1,0 starting with 1 at the first CONV cycle: DATA_0=20. With constant 0: DATA_0=0.
- CONT=1, IRQ_EN=1, software never clears done: the second LATCH sets overrun=1 and irq_o stays high. A W1C of 0x6 clears both.
- ABORT written 3 cycles into CONV: IDLE next cycle, mod_rst_o=1, DATA unchanged, done=0.
- mask=0x2 after a prior result of 36 in DATA_0: a new conversion updates DATA_1 only and DATA_0 stays 36. START during busy is ignored. Reads of offset 0x40 return 0 with ack.
- Assert wb_rst_i mid-CONV: all outputs and registers at reset values asynchronously. The next START runs normally.
